// File: rtl/space_wire_link_fsm.sv
// SpaceWire link-interface state machine: sequences ErrorReset/ErrorWait/Ready/
// Started/Connecting/Run and drives registered receiver/transmitter enables.
module space_wire_link_fsm #(
  parameter int unsigned TIMER_6US4_CYCLES  = 320,
  parameter int unsigned TIMER_12US8_CYCLES = 640
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_link_start,
  input  logic       i_link_disable,
  input  logic       i_auto_start,
  input  logic       i_got_null,
  input  logic       i_got_fct,
  input  logic       i_got_nchar,
  input  logic       i_got_time_code,
  input  logic       i_rx_error,
  input  logic       i_credit_error,
  output logic       o_rx_reset_n,
  output logic       o_tx_enable,
  output logic       o_send_fct_enable,
  output logic       o_send_data_enable,
  output logic [2:0] o_link_state,
  output logic       o_link_error
);

  typedef enum logic [2:0] {
    S_ERROR_RESET = 3'd0,
    S_ERROR_WAIT  = 3'd1,
    S_READY       = 3'd2,
    S_STARTED     = 3'd3,
    S_CONNECTING  = 3'd4,
    S_RUN         = 3'd5
  } state_e;

  localparam int unsigned TMAX = (TIMER_6US4_CYCLES > TIMER_12US8_CYCLES) ?
                                 TIMER_6US4_CYCLES : TIMER_12US8_CYCLES;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T6_LAST  = TW'(TIMER_6US4_CYCLES - 1);
  localparam logic [TW-1:0] T12_LAST = TW'(TIMER_12US8_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            null_seen_q, null_seen_d;
  logic            link_error_d;
  logic            rx_reset_n_q, tx_enable_q, fct_enable_q, data_enable_q, link_error_q;

  logic link_enabled;
  logic pre_run_error;
  logic t12_expired;

  assign link_enabled  = !i_link_disable & (i_link_start | (i_auto_start & null_seen_q));
  assign pre_run_error = i_rx_error | i_got_fct | i_got_nchar | i_got_time_code;
  assign t12_expired   = (timer_q == T12_LAST);

  // Branch order inside each state encodes priority: error, then timeout, then progress.
  always_comb begin
    state_d      = state_q;
    link_error_d = 1'b0;
    unique case (state_q)
      S_ERROR_RESET: begin
        if (timer_q == T6_LAST) state_d = S_ERROR_WAIT;
      end
      S_ERROR_WAIT: begin
        if (pre_run_error) begin
          state_d      = S_ERROR_RESET;
          link_error_d = 1'b1;
        end else if (t12_expired) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (pre_run_error) begin
          state_d      = S_ERROR_RESET;
          link_error_d = 1'b1;
        end else if (link_enabled) begin
          state_d = S_STARTED;
        end
      end
      S_STARTED: begin
        if (pre_run_error | i_link_disable | t12_expired) begin
          state_d      = S_ERROR_RESET;
          link_error_d = 1'b1;
        end else if (i_got_null) begin
          state_d = S_CONNECTING;
        end
      end
      S_CONNECTING: begin
        if (i_rx_error | i_got_nchar | i_got_time_code | i_link_disable | t12_expired) begin
          state_d      = S_ERROR_RESET;
          link_error_d = 1'b1;
        end else if (i_got_fct) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_rx_error | i_credit_error | i_link_disable) begin
          state_d      = S_ERROR_RESET;
          link_error_d = 1'b1;
        end
      end
      default: begin
        state_d = S_ERROR_RESET;
      end
    endcase
  end

  always_comb begin
    timer_d     = (state_d != state_q) ? '0 : timer_q + 1'b1;
    null_seen_d = null_seen_q;
    if (state_d == S_ERROR_RESET)
      null_seen_d = 1'b0;
    else if (i_got_null && (state_q == S_ERROR_WAIT || state_q == S_READY))
      null_seen_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= S_ERROR_RESET;
      timer_q       <= '0;
      null_seen_q   <= 1'b0;
      rx_reset_n_q  <= 1'b0;
      tx_enable_q   <= 1'b0;
      fct_enable_q  <= 1'b0;
      data_enable_q <= 1'b0;
      link_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      null_seen_q   <= null_seen_d;
      rx_reset_n_q  <= (state_d != S_ERROR_RESET);
      tx_enable_q   <= (state_d == S_STARTED) || (state_d == S_CONNECTING) || (state_d == S_RUN);
      fct_enable_q  <= (state_d == S_CONNECTING) || (state_d == S_RUN);
      data_enable_q <= (state_d == S_RUN);
      link_error_q  <= link_error_d;
    end
  end

  assign o_rx_reset_n       = rx_reset_n_q;
  assign o_tx_enable        = tx_enable_q;
  assign o_send_fct_enable  = fct_enable_q;
  assign o_send_data_enable = data_enable_q;
  assign o_link_state       = state_q;
  assign o_link_error       = link_error_q;

endmodule

// File: tb/tb_space_wire_link_fsm.sv
// Directed bench for space_wire_link_fsm with short timers (8 / 16 cycles).
module tb_space_wire_link_fsm;

  logic       clk = 1'b0;
  logic       reset_n, link_start, link_disable, auto_start;
  logic       got_null, got_fct, got_nchar, got_time_code, rx_error, credit_error;
  logic       rx_reset_n, tx_enable, fct_enable, data_enable, link_error;
  logic [2:0] link_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  space_wire_link_fsm #(
    .TIMER_6US4_CYCLES (8),
    .TIMER_12US8_CYCLES(16)
  ) dut (
    .i_clk             (clk),
    .i_reset_n         (reset_n),
    .i_link_start      (link_start),
    .i_link_disable    (link_disable),
    .i_auto_start      (auto_start),
    .i_got_null        (got_null),
    .i_got_fct         (got_fct),
    .i_got_nchar       (got_nchar),
    .i_got_time_code   (got_time_code),
    .i_rx_error        (rx_error),
    .i_credit_error    (credit_error),
    .o_rx_reset_n      (rx_reset_n),
    .o_tx_enable       (tx_enable),
    .o_send_fct_enable (fct_enable),
    .o_send_data_enable(data_enable),
    .o_link_state      (link_state),
    .o_link_error      (link_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    link_start = 0; link_disable = 0; auto_start = 0;
    got_null = 0; got_fct = 0; got_nchar = 0; got_time_code = 0;
    rx_error = 0; credit_error = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic to_started();
    do_reset();
    link_start = 1;
    repeat (25) tick();
  endtask

  task automatic to_connecting();
    to_started();
    got_null = 1; tick(); got_null = 0;
  endtask

  task automatic to_run();
    to_connecting();
    got_fct = 1; tick(); got_fct = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rx_reset_n, tx_enable, fct_enable, data_enable, link_state, link_error} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got rx=%b tx=%b fct=%b data=%b state=%0d err=%b, expected all 0",
               rx_reset_n, tx_enable, fct_enable, data_enable, link_state, link_error);
    end
  endtask

  task automatic test_bringup();
    do_reset();
    link_start = 1;
    repeat (7) tick();
    n_checks++;
    if (link_state !== 3'd0) begin n_fail++; $display("FAIL er_dwell: state=%0d expected=0", link_state); end
    tick();
    n_checks++;
    if (link_state !== 3'd1 || rx_reset_n !== 1'b1) begin
      n_fail++; $display("FAIL enter_ew: state=%0d rx=%b expected state=1 rx=1", link_state, rx_reset_n);
    end
    repeat (15) tick();
    n_checks++;
    if (link_state !== 3'd1) begin n_fail++; $display("FAIL ew_dwell: state=%0d expected=1", link_state); end
    tick();
    n_checks++;
    if (link_state !== 3'd2 || tx_enable !== 1'b0) begin
      n_fail++; $display("FAIL enter_ready: state=%0d tx=%b expected state=2 tx=0", link_state, tx_enable);
    end
    tick();
    n_checks++;
    if (link_state !== 3'd3 || tx_enable !== 1'b1 || fct_enable !== 1'b0) begin
      n_fail++; $display("FAIL enter_started: state=%0d tx=%b fct=%b expected 3/1/0", link_state, tx_enable, fct_enable);
    end
    repeat (4) tick();
    got_null = 1; tick(); got_null = 0;
    n_checks++;
    if (link_state !== 3'd4 || fct_enable !== 1'b1 || data_enable !== 1'b0) begin
      n_fail++; $display("FAIL enter_connecting: state=%0d fct=%b data=%b expected 4/1/0", link_state, fct_enable, data_enable);
    end
    repeat (2) tick();
    got_fct = 1; tick(); got_fct = 0;
    n_checks++;
    if (link_state !== 3'd5 || data_enable !== 1'b1 || tx_enable !== 1'b1) begin
      n_fail++; $display("FAIL enter_run: state=%0d data=%b tx=%b expected 5/1/1", link_state, data_enable, tx_enable);
    end
    repeat (40) tick();
    n_checks++;
    if (link_state !== 3'd5 || link_error !== 1'b0) begin
      n_fail++; $display("FAIL run_no_timeout: state=%0d err=%b expected 5/0", link_state, link_error);
    end
  endtask

  task automatic test_auto_start();
    do_reset();
    auto_start = 1;
    repeat (8) tick();
    got_null = 1; tick(); got_null = 0;
    repeat (14) tick();
    n_checks++;
    if (link_state !== 3'd1) begin n_fail++; $display("FAIL auto_ew: state=%0d expected=1", link_state); end
    tick();
    n_checks++;
    if (link_state !== 3'd2) begin n_fail++; $display("FAIL auto_ready: state=%0d expected=2", link_state); end
    tick();
    n_checks++;
    if (link_state !== 3'd3) begin n_fail++; $display("FAIL auto_started: state=%0d expected=3", link_state); end

    do_reset();
    auto_start = 1; link_disable = 1;
    repeat (8) tick();
    got_null = 1; tick(); got_null = 0;
    repeat (20) tick();
    n_checks++;
    if (link_state !== 3'd2 || link_error !== 1'b0) begin
      n_fail++; $display("FAIL auto_disabled: state=%0d err=%b expected 2/0", link_state, link_error);
    end

    // NULL arriving in Ready: flag sets first, Started follows one cycle later
    do_reset();
    auto_start = 1;
    repeat (25) tick();
    n_checks++;
    if (link_state !== 3'd2) begin n_fail++; $display("FAIL auto_wait_ready: state=%0d expected=2", link_state); end
    got_null = 1; tick(); got_null = 0;
    n_checks++;
    if (link_state !== 3'd2) begin n_fail++; $display("FAIL auto_null_ready: state=%0d expected=2", link_state); end
    tick();
    n_checks++;
    if (link_state !== 3'd3) begin n_fail++; $display("FAIL auto_ready_started: state=%0d expected=3", link_state); end
  endtask

  task automatic test_started_timeout();
    to_started();
    repeat (15) tick();
    n_checks++;
    if (link_state !== 3'd3 || link_error !== 1'b0) begin
      n_fail++; $display("FAIL started_pre_timeout: state=%0d err=%b expected 3/0", link_state, link_error);
    end
    tick();
    n_checks++;
    if (link_state !== 3'd0 || link_error !== 1'b1 || tx_enable !== 1'b0) begin
      n_fail++; $display("FAIL started_timeout: state=%0d err=%b tx=%b expected 0/1/0", link_state, link_error, tx_enable);
    end
    tick();
    n_checks++;
    if (link_error !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: err=%b expected=0", link_error); end
  endtask

  task automatic test_credit_error();
    to_run();
    credit_error = 1; tick(); credit_error = 0;
    n_checks++;
    if (link_state !== 3'd0 || data_enable !== 1'b0 || rx_reset_n !== 1'b0 || link_error !== 1'b1) begin
      n_fail++; $display("FAIL credit_error: state=%0d data=%b rx=%b err=%b expected 0/0/0/1",
                         link_state, data_enable, rx_reset_n, link_error);
    end
    tick();
    n_checks++;
    if (link_error !== 1'b0 || link_state !== 3'd0) begin
      n_fail++; $display("FAIL credit_err_pulse: err=%b state=%0d expected 0/0", link_error, link_state);
    end
    to_run();
    link_disable = 1; tick(); link_disable = 0;
    n_checks++;
    if (link_state !== 3'd0 || link_error !== 1'b1) begin
      n_fail++; $display("FAIL run_disable: state=%0d err=%b expected 0/1", link_state, link_error);
    end
  endtask

  task automatic test_errorwait_fct();
    do_reset();
    link_start = 1;
    repeat (11) tick();
    got_fct = 1; tick(); got_fct = 0;
    n_checks++;
    if (link_state !== 3'd0 || link_error !== 1'b1) begin
      n_fail++; $display("FAIL ew_fct: state=%0d err=%b expected 0/1", link_state, link_error);
    end
    repeat (7) tick();
    n_checks++;
    if (link_state !== 3'd0) begin n_fail++; $display("FAIL ew_fct_redwell: state=%0d expected=0", link_state); end
    tick();
    n_checks++;
    if (link_state !== 3'd1) begin n_fail++; $display("FAIL ew_fct_rewait: state=%0d expected=1", link_state); end
  endtask

  task automatic test_simultaneous();
    to_started();
    got_null = 1; got_fct = 1; tick(); got_null = 0; got_fct = 0;
    n_checks++;
    if (link_state !== 3'd0 || link_error !== 1'b1) begin
      n_fail++; $display("FAIL null_fct_started: state=%0d err=%b expected 0/1", link_state, link_error);
    end
    to_connecting();
    repeat (15) tick();
    n_checks++;
    if (link_state !== 3'd4) begin n_fail++; $display("FAIL conn_pre_timeout: state=%0d expected=4", link_state); end
    got_fct = 1; tick(); got_fct = 0;
    n_checks++;
    if (link_state !== 3'd0 || link_error !== 1'b1) begin
      n_fail++; $display("FAIL conn_timeout_fct: state=%0d err=%b expected 0/1", link_state, link_error);
    end
  endtask

  task automatic test_reset_in_run();
    to_run();
    reset_n = 0; tick(); reset_n = 1;
    n_checks++;
    if ({rx_reset_n, tx_enable, fct_enable, data_enable, link_state, link_error} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_in_run: got rx=%b tx=%b fct=%b data=%b state=%0d err=%b, expected all 0",
               rx_reset_n, tx_enable, fct_enable, data_enable, link_state, link_error);
    end
    tick();
    n_checks++;
    if (link_error !== 1'b0 || link_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_no_err: err=%b state=%0d expected 0/0", link_error, link_state);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_auto_start();
    test_started_timeout();
    test_credit_error();
    test_errorwait_fct();
    test_simultaneous();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/space_wire_link_fsm.md
Name: space_wire_link_fsm

Overview:
- SpaceWire link-interface state machine (ECSS-E-ST-50-12C): ErrorReset, ErrorWait, Ready, Started, Connecting, Run.
- Sits directly downstream of the one-pulse synchronisers. It consumes receiver-domain event pulses after they have been re-timed to i_clk.
- Drives the enables for the receiver and transmitter, plus the link status.

Parameters:
- TIMER_6US4_CYCLES, 320, i_clk cycles spent in ErrorReset (6.4 us at 50 MHz); minimum value 2.
- TIMER_12US8_CYCLES, 640, i_clk cycles for the ErrorWait dwell and for the Started/Connecting timeouts; minimum value 2.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous, active-low reset
- i_link_start  in  1  level; host requests link start
- i_link_disable  in  1  level; host forces link down
- i_auto_start  in  1  level; start on first received NULL
- i_got_null  in  1  one-cycle pulse, synchronised
- i_got_fct  in  1  one-cycle pulse, synchronised
- i_got_nchar  in  1  one-cycle pulse, synchronised
- i_got_time_code  in  1  one-cycle pulse, synchronised
- i_rx_error  in  1  one-cycle pulse, synchronised; covers disconnect, parity and escape errors
- i_credit_error  in  1  one-cycle pulse; credit error from the transmit credit counter
- o_rx_reset_n  out  1  0 holds the receiver in reset
- o_tx_enable  out  1  transmitter active (sending NULLs)
- o_send_fct_enable  out  1  FCTs may be sent
- o_send_data_enable  out  1  N-Chars and time-codes may be sent
- o_link_state  out  3  0 ErrorReset, 1 ErrorWait, 2 Ready, 3 Started, 4 Connecting, 5 Run
- o_link_error  out  1  one-cycle pulse on each error- or timeout-driven entry to ErrorReset

Behaviour:
- Reset
  - i_reset_n sampled low at a clock edge puts the block into ErrorReset with timer=0 and got_null_seen=0.
  - All outputs are 0 at reset: o_rx_reset_n=0, o_tx_enable=0, o_send_fct_enable=0, o_send_data_enable=0, o_link_state=0, o_link_error=0.
  - Reset applied mid-operation has the same effect from any state.
- Outputs
  - All outputs are registered and change on the same edge as the state register.
- Timer
  - Single counter, cleared on every state change.
  - In a timed state, the transition fires in the cycle where timer == N-1, so the dwell is exactly N cycles.
- Link enable
  - link_enabled = !i_link_disable & (i_link_start | (i_auto_start & got_null_seen)).
- got_null_seen
  - Set by i_got_null while in ErrorWait or Ready.
  - Cleared on entry to ErrorReset.
- Transition priority within a cycle: error conditions, then timeout, then progress event.
- States and transitions:
  - ErrorReset: rx held in reset, tx off. Goes to ErrorWait after TIMER_6US4_CYCLES. All input pulses are ignored.
  - ErrorWait: o_rx_reset_n=1, tx off.
    - i_rx_error, i_got_fct, i_got_nchar or i_got_time_code -> ErrorReset.
    - Otherwise -> Ready after TIMER_12US8_CYCLES.
  - Ready: rx on, tx off.
    - Same four error events -> ErrorReset.
    - link_enabled -> Started. A NULL arriving with auto-start set reaches Started one cycle after got_null_seen is set.
  - Started: o_tx_enable=1.
    - Error events (rx_error, fct, nchar, time_code) -> ErrorReset.
    - TIMER_12US8_CYCLES without a NULL -> ErrorReset.
    - i_got_null -> Connecting.
  - Connecting: tx and fct enabled.
    - i_rx_error, i_got_nchar or i_got_time_code -> ErrorReset.
    - Timeout (TIMER_12US8_CYCLES) -> ErrorReset.
    - i_got_fct -> Run.
  - Run: tx, fct and data enabled.
    - i_rx_error, i_credit_error or i_link_disable -> ErrorReset.
    - No timeout in Run.
- i_link_disable
  - Forces ErrorReset from Started, Connecting or Run.
  - In Ready it blocks the move to Started.
- o_link_error
  - Asserted for one cycle together with any entry to ErrorReset from ErrorWait, Ready, Started, Connecting or Run. This covers errors, timeouts and link_disable.
  - Not asserted for the entry caused by reset.
- Simultaneous events
  - In Started, i_got_null with i_got_fct in the same cycle -> ErrorReset (error wins).
  - In Connecting, i_got_fct coinciding with the timeout cycle -> ErrorReset (timeout beats progress).

Test Plan (TIMER_6US4_CYCLES=8, TIMER_12US8_CYCLES=16):
- Release reset with i_link_start=1, pulse i_got_null 5 cycles after Started, pulse i_got_fct 3 cycles after Connecting.
  - o_link_state goes 0 (8 cycles) -> 1 (16 cycles) -> 2 -> 3 -> 4 -> 5.
  - o_send_data_enable=1 in Run.
- Auto-start: i_auto_start=1, i_link_start=0, i_got_null pulsed in ErrorWait. Block reaches Ready, then enters Started on the next cycle.
  - Same case with i_link_disable=1: the block stays in Ready (state=2).
- In Started, no NULL is received -> after exactly 16 cycles state=0 and o_link_error pulses for 1 cycle.
- In Run, pulse i_credit_error -> next edge state=0, o_send_data_enable=0, o_rx_reset_n=0, o_link_error=1 for one cycle.
- In ErrorWait, pulse i_got_fct -> ErrorReset, and a full 8-cycle ErrorReset dwell restarts.
  - i_got_null and i_got_fct together in Started -> ErrorReset.
- In Run, assert i_reset_n=0 for one edge -> all outputs 0, state=0, and o_link_error stays 0.
